cpu_control_fsm: RTL

Moore-style controller that sequences the register-file/ALU datapath of the CPU for the six-instruction ALU/MOV subset. It latches the opcode fields of the instruction register on `s`, then steps the datapath through register reads, ALU evaluation and write-back, one enable per cycle. It signals `w` when idle and ready for the next instruction.

---
 rtl/cpu_control_fsm.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cpu_control_fsm.sv
// Moore controller sequencing register reads, ALU evaluation and write-back for the ALU/MOV subset.
// Outputs are registered from next-state; enables and bad_op are gated off while reset is high.
module cpu_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       bad_op
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WB_REG, S_WB_IMM
  } state_t;

  localparam logic [4:0] C_MOV_IMM = 5'b110_10;
  localparam logic [4:0] C_MOV_REG = 5'b110_00;
  localparam logic [4:0] C_MVN     = 5'b101_11;
  localparam logic [4:0] C_ADD     = 5'b101_00;
  localparam logic [4:0] C_CMP     = 5'b101_01;
  localparam logic [4:0] C_AND     = 5'b101_10;

  state_t     r_state;
  logic [4:0] r_code;
  state_t     w_next_state;
  logic [4:0] w_next_code;
  logic       w_next_bad;

  logic       r_w;
  logic [2:0] r_nsel;
  logic [1:0] r_vsel;
  logic       r_write, r_loada, r_loadb, r_loadc, r_loads, r_asel, r_bad_op;

  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_code;
    w_next_bad   = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (s) begin
          w_next_state = S_DECODE;
          w_next_code  = {opcode, op};
        end
      end
      S_DECODE: begin
        case (r_code)
          C_MOV_IMM:             w_next_state = S_WB_IMM;
          C_MOV_REG, C_MVN:      w_next_state = S_GET_B;
          C_ADD, C_CMP, C_AND:   w_next_state = S_GET_A;
          default:               w_next_state = S_WAIT;
        endcase
      end
      S_GET_A:  w_next_state = S_GET_B;
      S_GET_B:  w_next_state = S_ALU;
      S_ALU:    w_next_state = (r_code == C_CMP) ? S_WAIT : S_WB_REG;
      S_WB_REG: w_next_state = S_WAIT;
      S_WB_IMM: w_next_state = S_WAIT;
      default:  w_next_state = S_WAIT;
    endcase
    // Unsupported codes are flagged for the single DECODE cycle that follows the latch.
    if (w_next_state == S_DECODE) begin
      case (w_next_code)
        C_MOV_IMM, C_MOV_REG, C_MVN, C_ADD, C_CMP, C_AND: w_next_bad = 1'b0;
        default:                                          w_next_bad = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_WAIT;
      r_code   <= 5'b00000;
      r_w      <= 1'b1;
      r_nsel   <= 3'b000;
      r_vsel   <= 2'b00;
      r_write  <= 1'b0;
      r_loada  <= 1'b0;
      r_loadb  <= 1'b0;
      r_loadc  <= 1'b0;
      r_loads  <= 1'b0;
      r_asel   <= 1'b0;
      r_bad_op <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_code   <= w_next_code;
      r_w      <= (w_next_state == S_WAIT);
      r_nsel   <= (w_next_state == S_GET_A || w_next_state == S_WB_IMM) ? 3'b100 :
                  (w_next_state == S_GET_B)  ? 3'b001 :
                  (w_next_state == S_WB_REG) ? 3'b010 : 3'b000;
      r_vsel   <= (w_next_state == S_WB_IMM) ? 2'b01 : 2'b00;
      r_write  <= (w_next_state == S_WB_REG) || (w_next_state == S_WB_IMM);
      r_loada  <= (w_next_state == S_GET_A);
      r_loadb  <= (w_next_state == S_GET_B);
      r_loadc  <= (w_next_state == S_ALU) && (w_next_code != C_CMP);
      r_loads  <= (w_next_state == S_ALU) && (w_next_code == C_CMP);
      r_asel   <= (w_next_state == S_ALU) &&
                  ((w_next_code == C_MOV_REG) || (w_next_code == C_MVN));
      r_bad_op <= w_next_bad;
    end
  end

  assign w      = r_w;
  assign nsel   = r_nsel;
  assign vsel   = r_vsel;
  assign asel   = r_asel;
  assign bsel   = 1'b0;
  // Reset aborts an instruction in the same cycle, so no write or status load can slip out.
  assign write  = r_write  & ~reset;
  assign loada  = r_loada  & ~reset;
  assign loadb  = r_loadb  & ~reset;
  assign loadc  = r_loadc  & ~reset;
  assign loads  = r_loads  & ~reset;
  assign bad_op = r_bad_op & ~reset;

endmodule
